fir_frame_sequencer: RTL
========================

// Module: fir_frame_sequencer
// PURPOSE
//  Sequences one audio frame through the AXI-Stream FIR core: paces input samples
//  into the FIR at a fixed beat rate, then appends FLUSH_LEN zero samples to push
//  the filter tail out, and collects every FIR output beat, tagging the last one.
//  Sits between the sample source (file/ADC path) and the FIR core; the FIR output
//  stream has no back-pressure, so this block never stalls it.
// PARAMETERS
//  DATA_W    16    sample width, two's complement
//  LEN_W     16    width of frame_len; max frame length is 2^LEN_W-1
//  RATE_DIV  4     min aclk cycles between FIR input beats (>=1; 1 = every cycle)
//  FLUSH_LEN 32    zero samples appended after the frame (>= FIR taps-1, >=1)
//  TIMEOUT   1024  idle cycles in DRAIN, with no FIR output, before abort
// PORTS
//  aclk           in   1       clock, all logic on rising edge
//  rst            in   1       synchronous reset, active-high
//  start          in   1       start frame; sampled only in IDLE
//  frame_len      in   LEN_W   samples in frame; latched on start
//  busy           out  1       high in every state except IDLE
//  done           out  1       one-cycle pulse at frame end
//  err            out  1       sticky: drain timeout or stray FIR output; cleared by start
//  src_tvalid     in   1       source sample valid
//  src_tdata      in   DATA_W  source sample
//  src_tready     out  1       source accept
//  fir_s_tvalid   out  1       to FIR s_axis_data_tvalid
//  fir_s_tdata    out  DATA_W  to FIR s_axis_data_tdata
//  fir_s_tready   in   1       from FIR s_axis_data_tready
//  fir_m_tvalid   in   1       from FIR m_axis_data_tvalid
//  fir_m_tdata    in   DATA_W  from FIR m_axis_data_tdata
//  dst_tvalid     out  1       filtered sample valid (no ready; consumer must keep up)
//  dst_tdata      out  DATA_W  filtered sample
//  dst_tlast      out  1       marks beat number frame_len+FLUSH_LEN
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; hold register, counters, pace counter, err cleared.
//   Reset mid-frame abandons the frame; fir_s_tvalid drops the next cycle regardless.
//  FSM IDLE->FEED->FLUSH->DRAIN->DONE->IDLE.
//  IDLE: start=1 latches frame_len, clears err, zeroes counters. frame_len=0 ->
//   DONE directly (done pulses next cycle). start while busy is ignored.
//  Hold register: one entry driving fir_s_tdata; fir_s_tvalid=1 while full. Once
//   asserted, fir_s_tvalid/tdata hold until fir_s_tready=1 (AXIS rule).
//  Pacing: pace counter reloads RATE_DIV-1 on each FIR handshake and decrements
//   to 0; hold register may refill only when empty-after-handshake and pace==0.
//  FEED: src_tready = (hold empty) & (pace==0) & (in_cnt<frame_len). Source beat
//   loads hold reg. Leave to FLUSH when in_cnt==frame_len and that last beat has
//   handshaken into the FIR.
//  FLUSH: same pacing, hold loaded with 0; src_tready=0. After FLUSH_LEN zero
//   beats handshaken -> DRAIN.
//  Output path: dst_tvalid/tdata = fir_m_tvalid/tdata registered, 1-cycle latency,
//   in FEED/FLUSH/DRAIN. out_cnt counts beats; dst_tlast=1 on beat
//   out_cnt==frame_len+FLUSH_LEN. Counters are LEN_W+1 bits (no overflow).
//  fir_m_tvalid in IDLE/DONE: beat dropped, dst_tvalid stays 0, err set.
//  DRAIN: exit to DONE when the tlast beat has been emitted, or when TIMEOUT
//   consecutive cycles pass with fir_m_tvalid=0 (sets err; no tlast emitted).
//   Beats beyond frame_len+FLUSH_LEN: forwarded without tlast, set err.
//  DONE: done=1 for exactly one cycle, busy=1 that cycle; next state IDLE.
//  Simultaneous FIR in- and out-handshakes in one cycle are both counted.
// TESTING
//  1 reset, frame_len=8, RATE_DIV=4, tready=1, FIR model=identity 3-cycle delay ->
//    8 data + 32 zero FIR beats, spaced exactly 4 cycles; 40 dst beats, tlast on 40th.
//  2 fir_s_tready low 10 cycles mid-FEED -> fir_s_tvalid/tdata held stable, no loss,
//    src_tready low throughout; pacing resumes from the handshake.
//  3 start with frame_len=0 -> done pulse 1 cycle later, no FIR beats, busy low after.
//  4 FIR model stops emitting after 20 outputs -> err=1 after TIMEOUT idle cycles,
//    done pulses, no tlast; next start clears err.
//  5 rst asserted mid-FLUSH -> all outputs 0 next cycle, state IDLE; new frame_len=4
//    frame completes normally with tlast on beat 36.
//  6 fir_m_tvalid pulsed while IDLE -> dst_tvalid stays 0, err=1.

Source files
------------

// File: rtl/fir_frame_sequencer.sv
// Paces one frame of samples into an AXI-Stream FIR, appends zero flush samples,
// and forwards the FIR output stream with tlast on the final expected beat.
module fir_frame_sequencer #(
  parameter int DATA_W    = 16,
  parameter int LEN_W     = 16,
  parameter int RATE_DIV  = 4,
  parameter int FLUSH_LEN = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              src_tvalid,
  input  logic [DATA_W-1:0] src_tdata,
  output logic              src_tready,
  output logic              fir_s_tvalid,
  output logic [DATA_W-1:0] fir_s_tdata,
  input  logic              fir_s_tready,
  input  logic              fir_m_tvalid,
  input  logic [DATA_W-1:0] fir_m_tdata,
  output logic              dst_tvalid,
  output logic [DATA_W-1:0] dst_tdata,
  output logic              dst_tlast
);

  localparam int CW = LEN_W + 1;
  localparam int PW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam int FW = $clog2(FLUSH_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     len_q;
  logic [CW-1:0]     in_cnt;
  logic [CW-1:0]     out_cnt;
  logic [FW-1:0]     fl_cnt;
  logic [PW-1:0]     pace, pace_nxt;
  logic [TW-1:0]     idle_cnt;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;

  logic          fir_hs;
  logic          slot;
  logic          src_hs;
  logic          zero_ld;
  logic          active;
  logic          fwd;
  logic          stray;
  logic          out_last;
  logic          hold_drained;
  logic          timeout_hit;
  logic [CW-1:0] target;

  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign fir_s_tvalid = hold_valid;
  assign fir_s_tdata  = hold_data;

  assign fir_hs       = hold_valid & fir_s_tready;
  assign hold_drained = ~hold_valid | fir_hs;
  assign target       = len_q + CW'(FLUSH_LEN);
  assign out_last     = (out_cnt == target);
  assign active       = (state == S_FEED) | (state == S_FLUSH)
                      | (state == S_DRAIN);
  assign fwd          = active & fir_m_tvalid;
  assign stray        = ~active & fir_m_tvalid;

  // pace_nxt is the counter value in the cycle a freshly loaded beat is
  // presented, so a load is allowed only if that value will be zero.
  always_comb begin
    pace_nxt = pace;
    if (fir_hs)
      pace_nxt = PW'(RATE_DIV - 1);
    else if (pace != '0)
      pace_nxt = pace - PW'(1);
  end

  assign slot       = hold_drained & (pace_nxt == '0);
  assign src_tready = (state == S_FEED) & slot & (in_cnt < len_q);
  assign src_hs     = src_tready & src_tvalid;
  assign zero_ld    = (state == S_FLUSH) & slot
                    & (fl_cnt < FW'(FLUSH_LEN));
  assign timeout_hit = (state == S_DRAIN) & ~fir_m_tvalid & ~out_last
                     & (idle_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (start)
          state_nxt = (frame_len == '0) ? S_DONE : S_FEED;
      S_FEED:
        if ((in_cnt == len_q) && hold_drained)
          state_nxt = S_FLUSH;
      S_FLUSH:
        if ((fl_cnt == FW'(FLUSH_LEN)) && hold_drained)
          state_nxt = S_DRAIN;
      S_DRAIN:
        if (out_last || timeout_hit)
          state_nxt = S_DONE;
      S_DONE:
        state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state      <= S_IDLE;
      len_q      <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      fl_cnt     <= '0;
      pace       <= '0;
      idle_cnt   <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      err        <= 1'b0;
      dst_tvalid <= 1'b0;
      dst_tdata  <= '0;
      dst_tlast  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pace     <= pace_nxt;
      idle_cnt <= ((state == S_DRAIN) && !fir_m_tvalid)
                ? idle_cnt + TW'(1) : '0;

      if (fir_hs)
        hold_valid <= 1'b0;
      if (src_hs) begin
        hold_valid <= 1'b1;
        hold_data  <= src_tdata;
        in_cnt     <= in_cnt + CW'(1);
      end else if (zero_ld) begin
        hold_valid <= 1'b1;
        hold_data  <= '0;
        fl_cnt     <= fl_cnt + FW'(1);
      end

      dst_tvalid <= fwd;
      if (fwd)
        dst_tdata <= fir_m_tdata;
      dst_tlast <= fwd & ~out_last & (out_cnt + CW'(1) == target);
      // out_cnt saturates at target; anything past it is an extra beat
      if (fwd) begin
        if (out_last)
          err <= 1'b1;
        else
          out_cnt <= out_cnt + CW'(1);
      end
      if (timeout_hit)
        err <= 1'b1;

      if ((state == S_IDLE) && start) begin
        len_q   <= CW'(frame_len);
        in_cnt  <= '0;
        out_cnt <= '0;
        fl_cnt  <= '0;
        pace    <= '0;
        err     <= 1'b0;
      end
      if (stray)
        err <= 1'b1;
    end
  end

endmodule
